shared_mem_responder: RTL and testbench

//  Shared-memory responder for the GPU cores' load/store port. Arbitrates mem_req from
//  NUM_CORES cores, performs one 8-bit access per grant on an internal
//  MEM_DEPTH x DATA_W sync RAM, and answers with a one-cycle val_data pulse.

---
 rtl/shared_mem_responder_pkg.sv | 29 ++
 rtl/shared_mem_responder_if.sv | 29 ++
 rtl/shared_mem_responder_rr_arbiter.sv | 44 ++++
 rtl/shared_mem_responder.sv | 107 ++++++++++
 tb/tb_shared_mem_responder.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shared_mem_responder_pkg.sv
// Shared declarations for the GPU shared-memory responder: FSM state encoding,
// default bus widths and the one-hot to index helper used by the arbiter.
package gpu_mem_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 8;
    localparam int MAX_CORES  = 32;
    localparam int MAX_IDX_W  = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP,
        ST_CAP,
        ST_RELEASE
    } state_e;

    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_CORES-1:0] onehot);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_CORES; i++) begin
            if (onehot[i]) begin
                idx = idx | MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/shared_mem_responder_if.sv
// Core-array side bus of the shared-memory responder: per-core request lanes
// plus the broadcast response. master = core array, slave = responder.
interface shared_mem_responder_if
    import gpu_mem_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF
);

    logic [NUM_CORES-1:0]        mem_req;
    logic [NUM_CORES-1:0]        mem_we;
    logic [NUM_CORES*ADDR_W-1:0] addr;
    logic [NUM_CORES*DATA_W-1:0] wdata;
    logic [NUM_CORES-1:0]        val_data;
    logic [DATA_W-1:0]           rdata;
    logic                        busy;

    modport master (
        output mem_req, mem_we, addr, wdata,
        input  val_data, rdata, busy
    );

    modport slave (
        input  mem_req, mem_we, addr, wdata,
        output val_data, rdata, busy
    );

endinterface

// File: rtl/shared_mem_responder_rr_arbiter.sv
// Request arbiter: round-robin after last_grant by default; when FIXED_PRIO_EN
// is defined the lowest-index requester always wins and last_grant is ignored.
module rr_arbiter
    import gpu_mem_pkg::*;
#(
    parameter int NUM_CORES = 4,
    localparam int IDX_W    = $clog2(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req_i,
    input  logic [IDX_W-1:0]     last_grant_i,
    output logic [IDX_W-1:0]     grant_o,
    output logic                 valid_o
);

    logic [NUM_CORES-1:0] grant_oh;

`ifdef FIXED_PRIO_EN
    logic [IDX_W-1:0] unused_last_grant;
    assign unused_last_grant = last_grant_i;

    always_comb begin
        grant_oh = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                grant_oh = NUM_CORES'(1) << k;
            end
        end
    end
`else
    // Scan backwards so the candidate nearest last_grant+1 is written last and wins.
    always_comb begin
        grant_oh = '0;
        for (int k = NUM_CORES; k >= 1; k--) begin
            if (req_i[(int'(last_grant_i) + k) % NUM_CORES]) begin
                grant_oh = NUM_CORES'(1) << ((int'(last_grant_i) + k) % NUM_CORES);
            end
        end
    end
`endif

    assign grant_o = IDX_W'(onehot_to_idx(MAX_CORES'(grant_oh)));
    assign valid_o = |req_i;

endmodule

// File: rtl/shared_mem_responder.sv
// Shared-memory responder: arbitrates per-core load/store requests onto one
// internal sync RAM and answers with a one-cycle val_data pulse. Macro: FIXED_PRIO_EN.
module shared_mem_responder
    import gpu_mem_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MEM_DEPTH = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    shared_mem_responder_if.slave  mem_if
);

    localparam int IDX_W  = $clog2(NUM_CORES);
    localparam int MEM_AW = $clog2(MEM_DEPTH);

    state_e               state_q;
    logic [IDX_W-1:0]     grant_q;
    logic [IDX_W-1:0]     last_grant_q;
    logic [MEM_AW-1:0]    addr_q;
    logic                 we_q;
    logic [NUM_CORES-1:0] val_data_q;
    logic                 busy_q;

    logic [IDX_W-1:0]     arb_grant;
    logic                 arb_valid;

    logic [ADDR_W-1:0]    addr_arr  [NUM_CORES];
    logic [DATA_W-1:0]    wdata_arr [NUM_CORES];

    logic [DATA_W-1:0]    mem_q [MEM_DEPTH];
    logic [DATA_W-1:0]    ram_rd_q;

    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_unpack
        assign addr_arr[gi]  = mem_if.addr[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi] = mem_if.wdata[gi*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .NUM_CORES (NUM_CORES)
    ) u_arb (
        .req_i        (mem_if.mem_req),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant),
        .valid_o      (arb_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_CORES - 1);
            addr_q       <= '0;
            we_q         <= 1'b0;
            val_data_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arb_valid) begin
                        grant_q <= arb_grant;
                        addr_q  <= addr_arr[arb_grant][MEM_AW-1:0];
                        we_q    <= mem_if.mem_we[arb_grant];
                        busy_q  <= 1'b1;
                        state_q <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    val_data_q <= NUM_CORES'(1) << grant_q;
                    state_q    <= ST_RESP;
                end
                ST_RESP: begin
                    val_data_q <= '0;
                    state_q    <= we_q ? ST_CAP : ST_RELEASE;
                end
                ST_CAP: begin
                    state_q <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (!mem_if.mem_req[grant_q]) begin
                        last_grant_q <= grant_q;
                        busy_q       <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Write is gated by the live state, so a reset during ST_CAP aborts the store.
    always_ff @(posedge clk) begin
        if (state_q == ST_CAP) begin
            mem_q[addr_q] <= wdata_arr[grant_q];
        end
        ram_rd_q <= mem_q[addr_q];
    end

    assign mem_if.val_data = val_data_q;
    assign mem_if.busy     = busy_q;
    assign mem_if.rdata    = (|val_data_q) ? ram_rd_q : '0;

endmodule

// File: tb/tb_shared_mem_responder.sv
// Randomized self-checking bench for shared_mem_responder against a
// behavioural model of the memory contents and grant policy.
module tb_shared_mem_responder;

    localparam int NC = 4;
    localparam int AW = 12;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset;

    shared_mem_responder_if #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) bus ();

    shared_mem_responder #(
        .NUM_CORES (NC),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MEM_DEPTH (4096)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .mem_if (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [NC-1:0] req_v;
    logic [NC-1:0] we_v;
    logic [AW-1:0] cur_addr  [NC];
    logic [DW-1:0] cur_wdata [NC];
    int            reps      [NC];
    logic [DW-1:0] mdl_mem   [4096];
    bit            mdl_vld   [4096];
    int            last_g;
    int            order_q [$];
    logic [DW-1:0] last_rdata;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive();
        for (int i = 0; i < NC; i++) begin
            bus.addr[i*AW +: AW]  = cur_addr[i];
            bus.wdata[i*DW +: DW] = cur_wdata[i];
        end
        bus.mem_req = req_v;
        bus.mem_we  = we_v;
    endtask

    task automatic set_core(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        we_v[i]      = we;
        cur_addr[i]  = a;
        cur_wdata[i] = d;
        req_v[i]     = 1'b1;
        drive();
    endtask

    task automatic rand_op(input int i);
        set_core(i, 1'($urandom_range(0, 1)), AW'(12'h100 + $urandom_range(0, 15)), DW'($urandom));
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req_v = '0;
        drive();
        @(negedge clk);
        reset  = 1'b0;
        last_g = NC - 1;
        @(negedge clk);
    endtask

    // Grant policy from the requester set: nearest after the last winner, or lowest index.
    function automatic int exp_grant(input logic [NC-1:0] req);
`ifdef FIXED_PRIO_EN
        for (int k = 0; k < NC; k++) if (req[k]) return k;
`else
        for (int k = 1; k <= NC; k++) if (req[(last_g + k) % NC]) return (last_g + k) % NC;
`endif
        return -1;
    endfunction

    task automatic serve_all(input string tag);
        int g;
        int w;
        logic [NC-1:0] exp_oh;
        while (req_v != '0) begin
            w = 0;
            while (bus.val_data == '0 && w < 40) begin
                @(negedge clk);
                w++;
            end
            n_cmp++;
            if (w != 2) begin
                n_bad++;
                $display("FAIL %s latency: got %0d cycles, expected 2", tag, w);
            end
            if (bus.val_data == '0) begin
                apply_reset();
                return;
            end
            g = exp_grant(req_v);
            exp_oh = '0;
            exp_oh[g] = 1'b1;
            n_cmp++;
            if (bus.val_data !== exp_oh) begin
                n_bad++;
                $display("FAIL %s grant: val_data=%b expected %b", tag, bus.val_data, exp_oh);
            end
            if (!we_v[g]) begin
                last_rdata = bus.rdata;
                if (mdl_vld[cur_addr[g]]) begin
                    n_cmp++;
                    if (bus.rdata !== mdl_mem[cur_addr[g]]) begin
                        n_bad++;
                        $display("FAIL %s rdata core%0d addr=0x%03h: got 0x%02h expected 0x%02h",
                                 tag, g, cur_addr[g], bus.rdata, mdl_mem[cur_addr[g]]);
                    end
                end
            end else begin
                mdl_mem[cur_addr[g]] = cur_wdata[g];
                mdl_vld[cur_addr[g]] = 1'b1;
            end
            $display("txn %s core=%0d %s addr=0x%03h data=0x%02h", tag, g, we_v[g] ? "ST" : "LD",
                     cur_addr[g], we_v[g] ? cur_wdata[g] : bus.rdata);
            order_q.push_back(g);
            last_g   = g;
            req_v[g] = 1'b0;
            drive();
            @(negedge clk);
            n_cmp++;
            if (bus.val_data !== '0) begin
                n_bad++;
                $display("FAIL %s pulse: val_data=%b one cycle later, expected 0", tag, bus.val_data);
            end
            w = 0;
            while (bus.busy && w < 10) begin
                @(negedge clk);
                w++;
            end
            n_cmp++;
            if (bus.busy !== 1'b0) begin
                n_bad++;
                $display("FAIL %s release: busy=%b expected 0", tag, bus.busy);
                apply_reset();
                return;
            end
            if (reps[g] > 0) begin
                reps[g]--;
                rand_op(g);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.val_data !== '0) begin n_bad++; $display("FAIL reset val_data: got %b expected 0", bus.val_data); end
        n_cmp++;
        if (bus.rdata !== '0) begin n_bad++; $display("FAIL reset rdata: got 0x%02h expected 0", bus.rdata); end
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset busy: got %b expected 0", bus.busy); end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL idle busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_store_load();
        set_core(0, 1'b1, 12'h010, 8'h5A);
        serve_all("store010");
        set_core(0, 1'b0, 12'h010, 8'h00);
        serve_all("load010");
        n_cmp++;
        if (last_rdata !== 8'h5A) begin n_bad++; $display("FAIL load010: got 0x%02h expected 0x5A", last_rdata); end
    endtask

    task automatic test_reset_midrun();
        int w = 0;
        set_core(0, 1'b0, 12'h010, 8'h00);
        while (bus.val_data == '0 && w < 10) begin @(negedge clk); w++; end
        n_cmp++;
        if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL midrun busy before reset: got %b expected 1", bus.busy); end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (bus.val_data !== '0) begin n_bad++; $display("FAIL midrun val_data: got %b expected 0", bus.val_data); end
        n_cmp++;
        if (bus.rdata !== '0) begin n_bad++; $display("FAIL midrun rdata: got 0x%02h expected 0", bus.rdata); end
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL midrun busy: got %b expected 0", bus.busy); end
        req_v = '0;
        drive();
        @(negedge clk);
        reset  = 1'b0;
        last_g = NC - 1;
        @(negedge clk);
    endtask

    task automatic init_window();
        for (int a = 0; a < 16; a++) begin
            set_core($urandom_range(0, NC - 1), 1'b1, AW'(12'h100 + a), DW'($urandom));
            serve_all("init");
        end
    endtask

    task automatic test_three_core_rr();
        int exp_ord [6];
`ifdef FIXED_PRIO_EN
        exp_ord = '{0, 0, 1, 1, 2, 2};
`else
        exp_ord = '{0, 1, 2, 0, 1, 2};
`endif
        order_q.delete();
        for (int i = 0; i < 3; i++) begin
            reps[i] = 1;
            rand_op(i);
        end
        serve_all("rr3");
        n_cmp++;
        if (order_q.size() != 6) begin
            n_bad++;
            $display("FAIL rr3 count: got %0d grants expected 6", order_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_cmp++;
                if (order_q[i] != exp_ord[i]) begin
                    n_bad++;
                    $display("FAIL rr3 order[%0d]: got core%0d expected core%0d", i, order_q[i], exp_ord[i]);
                end
            end
        end
    endtask

    task automatic test_hold_release();
        int w = 0;
        set_core(1, 1'b0, 12'h010, 8'h00);
        while (bus.val_data == '0 && w < 10) begin @(negedge clk); w++; end
        n_cmp++;
        if (bus.val_data !== 4'b0010) begin n_bad++; $display("FAIL hold grant: got %b expected 0010", bus.val_data); end
        n_cmp++;
        if (bus.rdata !== mdl_mem[12'h010]) begin
            n_bad++;
            $display("FAIL hold rdata: got 0x%02h expected 0x%02h", bus.rdata, mdl_mem[12'h010]);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.busy !== 1'b1 || bus.val_data !== '0) begin
                n_bad++;
                $display("FAIL hold stall %0d: busy=%b val_data=%b expected 1/0000", k, bus.busy, bus.val_data);
            end
        end
        req_v[1] = 1'b0;
        drive();
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL hold drop: busy=%b expected 0", bus.busy); end
        $display("txn hold core=1 LD addr=0x010 held 5 cycles");
        last_g = 1;
    endtask

    task automatic test_reset_in_stcap();
        int w = 0;
        set_core(2, 1'b1, 12'h020, 8'h11);
        serve_all("st020");
        set_core(2, 1'b1, 12'h020, 8'h5A);
        while (bus.val_data == '0 && w < 10) begin @(negedge clk); w++; end
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL stcap busy: got %b expected 1", bus.busy); end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL stcap reset busy: got %b expected 0", bus.busy); end
        #2;
        reset = 1'b0;
        req_v = '0;
        drive();
        last_g = NC - 1;
        @(negedge clk);
        set_core(3, 1'b0, 12'h020, 8'h00);
        serve_all("ld020");
        n_cmp++;
        if (last_rdata !== 8'h11) begin n_bad++; $display("FAIL aborted store: got 0x%02h expected 0x11", last_rdata); end
    endtask

    task automatic test_random();
        logic [NC-1:0] mask;
        for (int r = 0; r < 8; r++) begin
            mask = NC'($urandom_range(1, (1 << NC) - 1));
            for (int i = 0; i < NC; i++) begin
                if (mask[i]) begin
                    reps[i] = $urandom_range(0, 2);
                    rand_op(i);
                end
            end
            serve_all("rand");
        end
    endtask

    task automatic test_prio();
        order_q.delete();
        reps[1] = 3;
        reps[3] = 3;
        set_core(1, 1'b0, 12'h100, 8'h00);
        set_core(3, 1'b0, 12'h101, 8'h00);
        serve_all("prio");
`ifdef FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (order_q.size() <= i || order_q[i] != 1) begin
                n_bad++;
                $display("FAIL prio pass %0d: core1 not granted", i);
            end
        end
`endif
    endtask

    initial begin
        reset  = 1'b1;
        req_v  = '0;
        we_v   = '0;
        last_g = NC - 1;
        last_rdata = '0;
        for (int i = 0; i < NC; i++) begin
            cur_addr[i]  = '0;
            cur_wdata[i] = '0;
            reps[i]      = 0;
        end
        drive();
        test_reset();
        test_store_load();
        test_reset_midrun();
        init_window();
        apply_reset();
        test_three_core_rr();
        test_hold_release();
        test_reset_in_stcap();
        test_random();
        test_prio();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
